// File: rtl/cache_rd_arbiter_pkg.sv
// Shared definitions for the cache read arbiter: FSM state encoding,
// owner codes and a small owner-to-one-hot helper.
package cache_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Bit 0 of a request/grant vector is the Icache, bit 1 the Dcache.
  function automatic logic [1:0] owner_onehot(input logic own);
    return (own == OWN_D) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cache_arb_rr_pick.sv
// 2-way round-robin pick. A lone request wins outright; on a tie the
// requester that did not win last time is chosen. The grant is combinational
// and is registered by the parent when it leaves IDLE.
module cache_arb_rr_pick
  import cache_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] grant
);

  // Pick one requester; on a tie alternate away from the last winner.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = owner_onehot(~last_owner);
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one AXI AR/R channel between the Icache and Dcache refill engines.
// One requester is granted at a time; its burst is issued on AR and its R
// beats are forwarded (registered, one cycle later) only to that requester.
// The grant is held until the last beat, followed by a one-cycle DONE state.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. ar_valid, once raised, holds ar_addr/ar_len/ar_id stable until
// ar_ready is seen. r_ready is high only while collecting beats (DATA).
// Refill requests are level-held by the caches until the cycle after rsp_last.
//
// Optional feature: define ARB_PERF_EN to add grant/wait performance counters.
module cache_rd_arbiter
  import cache_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [LEN_W-1:0]  i_req_len,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  output logic              i_rsp_last,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LEN_W-1:0]  d_req_len,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              d_rsp_last,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [LEN_W-1:0]  ar_len,
  output logic              ar_id,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic              r_last,
  output logic              busy,
  output logic              owner,
  output logic              len_err
`ifdef ARB_PERF_EN
  ,
  output logic [63:0]       i_grant_cnt,
  output logic [63:0]       d_grant_cnt,
  output logic [63:0]       wait_cnt
`endif
);

  arb_state_t        state, state_nxt;
  logic              owner_q;
  logic              rr_last_q;   // reset to D so the first tie goes to I
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [1:0]        grant;
  logic              take_grant;
  logic              beat;

  cache_arb_rr_pick u_pick (
    .req        ({d_req_valid, i_req_valid}),
    .last_owner (rr_last_q),
    .grant      (grant)
  );

  assign take_grant = (state == ST_IDLE) && (grant != 2'b00);
  assign beat       = (state == ST_DATA) && r_valid;

  assign ar_valid = (state == ST_ADDR);
  assign ar_addr  = addr_q;
  assign ar_len   = len_q;
  assign ar_id    = owner_q;
  assign r_ready  = (state == ST_DATA);
  assign busy     = (state != ST_IDLE);
  assign owner    = owner_q;

  // Next-state logic: IDLE -> ADDR -> DATA -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (take_grant)          state_nxt = ST_ADDR;
      ST_ADDR: if (ar_ready)            state_nxt = ST_DATA;
      ST_DATA: if (r_valid && r_last)   state_nxt = ST_DONE;
      ST_DONE:                          state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Grant capture: owner, round-robin history and the AR fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_I;
      rr_last_q <= OWN_D;
      addr_q    <= '0;
      len_q     <= '0;
    end else if (take_grant) begin
      owner_q   <= grant[1];
      rr_last_q <= grant[1];
      addr_q    <= grant[1] ? d_req_addr : i_req_addr;
      len_q     <= grant[1] ? d_req_len  : i_req_len;
    end
  end

  // Beat counter: cleared on AR acceptance, advanced per accepted R beat.
  always_ff @(posedge clk) begin
    if (rst)                                cnt_q <= '0;
    else if ((state == ST_ADDR) && ar_ready) cnt_q <= '0;
    else if (beat)                          cnt_q <= cnt_q + 1'b1;
  end

  // R demux: register each beat toward the owner; non-owner stays at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rsp_valid <= 1'b0;
      i_rsp_data  <= '0;
      i_rsp_last  <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      d_rsp_last  <= 1'b0;
    end else begin
      i_rsp_valid <= beat && (owner_q == OWN_I);
      i_rsp_data  <= (beat && (owner_q == OWN_I)) ? r_data : '0;
      i_rsp_last  <= beat && (owner_q == OWN_I) && r_last;
      d_rsp_valid <= beat && (owner_q == OWN_D);
      d_rsp_data  <= (beat && (owner_q == OWN_D)) ? r_data : '0;
      d_rsp_last  <= beat && (owner_q == OWN_D) && r_last;
    end
  end

  // Sticky length error: last beat early, or the expected final beat not last.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_err <= 1'b0;
    end else if (beat && ((r_last && (cnt_q != len_q)) ||
                          (!r_last && (cnt_q == len_q)))) begin
      len_err <= 1'b1;
    end
  end

`ifdef ARB_PERF_EN
  // Performance counters: grants per requester and cycles a loser waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
      wait_cnt    <= '0;
    end else begin
      if (take_grant && !grant[1]) i_grant_cnt <= i_grant_cnt + 64'd1;
      if (take_grant &&  grant[1]) d_grant_cnt <= d_grant_cnt + 64'd1;
      if (busy && (((owner_q == OWN_I) && d_req_valid) ||
                   ((owner_q == OWN_D) && i_req_valid)))
        wait_cnt <= wait_cnt + 64'd1;
    end
  end
`endif

endmodule
